// File: rtl/agendador_temporizador.sv
// agendador_temporizador: shares one tick-driven countdown timer among N
// requesters with round-robin arbitration and a one-clk done pulse per grant.
// Optional macro AGENDADOR_PAUSE_EN adds a 'pausa' input that freezes counting.
module agendador_temporizador #(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
`ifdef AGENDADOR_PAUSE_EN
    input  logic            pausa,
`endif
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] dur,
    output logic [N-1:0]    grant,
    output logic [N-1:0]    done,
    output logic            busy,
    output logic [DW-1:0]   restante
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [N-1:0]    grant_d;
    logic [N-1:0]    done_d;
    logic            busy_d;
    logic [DW-1:0]   cnt_d;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic [CW-1:0]   cand;
    logic [PW-1:0]   nxt_ptr;
    logic            cnt_tick;

`ifdef AGENDADOR_PAUSE_EN
    assign cnt_tick = tick & ~pausa;
`else
    assign cnt_tick = tick;
`endif

    // Pointer value after the current owner releases the timer (wraps N-1 -> 0).
    assign nxt_ptr = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + PW'(1);

    // Round-robin pick: first set req scanning upward from ptr with wrap-around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = CW'(ptr_q) + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!pick_valid && req[cand[PW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    // Next-state and next-output logic for the IDLE/COUNT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant;
        done_d  = '0;
        busy_d  = busy;
        cnt_d   = restante;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                if (pick_valid) begin
                    state_d           = COUNT;
                    gidx_d            = pick_idx;
                    grant_d[pick_idx] = 1'b1;
                    busy_d            = 1'b1;
                    cnt_d             = dur[pick_idx*DW +: DW];
                end
            end
            COUNT: begin
                if (!req[gidx_q]) begin
                    // Abort wins over expiry; no done pulse.
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    ptr_d   = nxt_ptr;
                end else if (restante == '0) begin
                    state_d = DONE;
                    grant_d = '0;
                    done_d  = grant;
                end else if (cnt_tick) begin
                    if (restante == DW'(1)) begin
                        state_d = DONE;
                        grant_d = '0;
                        done_d  = grant;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = restante - DW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
                ptr_d   = nxt_ptr;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, pointer and registered outputs; synchronous reset aborts at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
            restante <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant    <= grant_d;
            done     <= done_d;
            busy     <= busy_d;
            restante <= cnt_d;
        end
    end

endmodule

// File: tb/tb_agendador_temporizador.sv
// Self-checking bench for agendador_temporizador (N=3, DW=8).
// Expected grants/dones are queued at stimulus time and popped by a monitor.
module tb_agendador_temporizador;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            tick = 1'b0;
`ifdef AGENDADOR_PAUSE_EN
    logic            pausa = 1'b0;
`endif
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] dur = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [DW-1:0]   restante;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] exp_grant_q[$];
    logic [N-1:0] exp_done_q[$];
    logic [N-1:0] prev_grant = '0;

    agendador_temporizador #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
`ifdef AGENDADOR_PAUSE_EN
        .pausa    (pausa),
`endif
        .req      (req),
        .dur      (dur),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .restante (restante)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called on a falling edge; one tick is sampled by the (n)-th rising edge.
    task automatic tick_after(input int n);
        repeat (n - 1) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic set_dur(input int i, input logic [DW-1:0] v);
        dur[i*DW +: DW] = v;
    endtask

    task automatic expect_pair(input logic [N-1:0] g);
        exp_grant_q.push_back(g);
        exp_done_q.push_back(g);
    endtask

    // Scoreboard monitor: compares each new grant and each done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (grant != '0 && prev_grant == '0) begin
                    if (exp_grant_q.size() == 0) check("grant_unexpected", 32'(grant), 32'd0);
                    else check("grant_order", 32'(grant), 32'(exp_grant_q.pop_front()));
                end
                if (done != '0) begin
                    if (exp_done_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
                    else check("done_order", 32'(done), 32'(exp_done_q.pop_front()));
                end
            end
            prev_grant = grant;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_g;
        int cyc;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_restante", 32'(restante), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single request, tick during grant edge ignored
        set_dur(0, 8'd4);
        req  = 3'b001;
        tick = 1'b1;
        expect_pair(3'b001);
        @(negedge clk);
        tick = 1'b0;
        check("t1_grant", 32'(grant), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_restante0", 32'(restante), 32'd4);
        for (int k = 1; k <= 3; k++) begin
            tick_after(10);
            check("t1_restante", 32'(restante), 32'(4 - k));
            check("t1_no_done", 32'(done), 32'd0);
        end
        tick_after(10);
        check("t1_done", 32'(done), 32'd1);
        check("t1_grant_clr", 32'(grant), 32'd0);
        check("t1_busy_done", 32'(busy), 32'd1);
        check("t1_restante_done", 32'(restante), 32'd0);
        req = '0;
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_busy_fall", 32'(busy), 32'd0);

        // Zero duration on requester 1
        set_dur(1, 8'd0);
        req = 3'b010;
        expect_pair(3'b010);
        @(negedge clk);
        check("z_grant", 32'(grant), 32'd2);
        check("z_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("z_done", 32'(done), 32'd2);
        check("z_grant_clr", 32'(grant), 32'd0);
        req = '0;
        @(negedge clk);
        check("z_idle_busy", 32'(busy), 32'd0);
        check("z_idle_done", 32'(done), 32'd0);

        // Abort on requester 2, then index 0 wins
        set_dur(2, 8'd10);
        req = 3'b100;
        exp_grant_q.push_back(3'b100);
        @(negedge clk);
        check("ab_grant", 32'(grant), 32'd4);
        check("ab_restante0", 32'(restante), 32'd10);
        repeat (3) tick_after(10);
        check("ab_restante3", 32'(restante), 32'd7);
        set_dur(0, 8'd2);
        req = 3'b001;
        exp_grant_q.push_back(3'b001);
        @(negedge clk);
        check("ab_grant_clr", 32'(grant), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_restante", 32'(restante), 32'd0);
        check("ab_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("ab_next_winner", 32'(grant), 32'd1);
        req = '0;
        @(negedge clk);
        check("ab2_grant_clr", 32'(grant), 32'd0);
        check("ab2_no_done", 32'(done), 32'd0);

        // Reset in the middle of a count
        set_dur(1, 8'd8);
        req = 3'b010;
        exp_grant_q.push_back(3'b010);
        @(negedge clk);
        check("rm_grant", 32'(grant), 32'd2);
        repeat (3) tick_after(10);
        check("rm_restante", 32'(restante), 32'd5);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        check("rm_grant_clr", 32'(grant), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_restante0", 32'(restante), 32'd0);
        check("rm_no_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Round-robin fairness with all requesting
        dur = {8'd1, 8'd1, 8'd1};
        for (int r = 0; r < 4; r++) expect_pair(3'(1 << (r % 3)));
        req = 3'b111;
        for (int r = 0; r < 4; r++) begin
            exp_g = 3'(1 << (r % 3));
            cyc = 0;
            while (grant == '0 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("rr_grant_wait", 32'(cyc < 20), 32'd1);
            check("rr_grant", 32'(grant), 32'(exp_g));
            tick_after(3);
            check("rr_done", 32'(done), 32'(exp_g));
            req = req & ~exp_g;
            @(negedge clk);
            if (r < 3) req = req | exp_g;
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Maximum duration with a tick every clock
        set_dur(1, 8'd255);
        req = 3'b010;
        expect_pair(3'b010);
        @(negedge clk);
        check("mx_restante", 32'(restante), 32'd255);
        tick_after(1);
        check("mx_first_dec", 32'(restante), 32'd254);
        repeat (253) tick_after(1);
        check("mx_restante1", 32'(restante), 32'd1);
        tick_after(1);
        check("mx_done", 32'(done), 32'd2);
        req = '0;
        repeat (2) @(negedge clk);

`ifdef AGENDADOR_PAUSE_EN
        // Pause freezes the count; release resumes it
        set_dur(2, 8'd3);
        req   = 3'b100;
        pausa = 1'b1;
        expect_pair(3'b100);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            tick_after(4);
            check("pz_frozen", 32'(restante), 32'd3);
        end
        pausa = 1'b0;
        repeat (2) tick_after(4);
        check("pz_restante", 32'(restante), 32'd1);
        tick_after(4);
        check("pz_done", 32'(done), 32'd4);
        req = '0;
        repeat (2) @(negedge clk);
`endif

        check("grant_q_empty", 32'(exp_grant_q.size()), 32'd0);
        check("done_q_empty", 32'(exp_done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
